// File: rtl/leds_racer_input_hub_pkg.sv
// Shared definitions for the LEDs racer button front-end: player limits,
// board colour-to-index mapping and width helpers used by the hub and its channels.
package leds_racer_input_hub_pkg;

  // Largest number of button channels the hub supports.
  localparam int MAX_PLAYERS = 16;

  // Board colour of each player index.
  localparam int GREEN  = 0;
  localparam int RED    = 1;
  localparam int BLUE   = 2;
  localparam int YELLOW = 3;

  // Width of a player index; a single-player build still carries one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of a down/up counter that must hold the value n; n==0 still needs one bit.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/leds_racer_input_hub_if.sv
// Bundle between the board buttons / racer core and the input hub.
// The master side drives buttons and game controls; the slave side is the hub.
interface leds_racer_input_hub_if #(
  parameter int NUM_PLAYERS = 4
) ();

  localparam int ID_W = leds_racer_input_hub_pkg::id_width(NUM_PLAYERS);

  logic [NUM_PLAYERS-1:0] btn_in;
  logic                   clear;
  logic                   ready_en;
  logic                   race_armed;
  logic [NUM_PLAYERS-1:0] btn_level;
  logic [NUM_PLAYERS-1:0] btn_press;
  logic [NUM_PLAYERS-1:0] ready;
  logic                   all_ready;
  logic                   first_valid;
  logic [ID_W-1:0]        first_id;

  modport master (
    output btn_in, clear, ready_en, race_armed,
    input  btn_level, btn_press, ready, all_ready, first_valid, first_id
  );

  modport slave (
    input  btn_in, clear, ready_en, race_armed,
    output btn_level, btn_press, ready, all_ready, first_valid, first_id
  );

endinterface

// File: rtl/leds_racer_debounce_ch.sv
// One button channel: two-flop synchroniser, stable-time debounce,
// one-cycle press pulse on an accepted rising edge, and an optional
// lockout that drops rapid re-taps for a fixed number of cycles.
module leds_racer_debounce_ch
  import leds_racer_input_hub_pkg::*;
#(
  parameter int DEBOUNCE_CLK_CNT = 65536,
  parameter int LOCKOUT_CLK_CNT  = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CLK_CNT);
  localparam int LOCK_W = cnt_width(LOCKOUT_CLK_CNT);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CLK_CNT - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CLK_CNT);

  logic              sync_p0;
  logic              sync_p1;
  logic [CNT_W-1:0]  deb_cnt;
  logic              level_q;
  logic              press_q;
  logic [LOCK_W-1:0] lock_cnt;
  logic              raw_press;
  logic              press_ok;

  // The debounced level is about to rise on this edge.
  assign raw_press = sync_p1 & ~level_q & (deb_cnt == CNT_LAST);
  // A press is emitted only when the channel is not inside a lockout window.
  assign press_ok  = raw_press & (lock_cnt == '0);

  // Stage p0/p1: bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CLK_CNT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      level_q <= 1'b0;
    end else if (sync_p1 == level_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_LAST) begin
      level_q <= sync_p1;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CNT_W'(1);
    end
  end

  // Press pulse plus lockout timer; a dropped press never re-arms the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q  <= 1'b0;
      lock_cnt <= '0;
    end else begin
      press_q <= press_ok;
      if (press_ok) begin
        lock_cnt <= LOCK_LOAD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - LOCK_W'(1);
      end
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/leds_racer_input_hub.sv
// N-player button front-end for the LEDs racer. Each button runs through its
// own debounce channel; the hub then keeps the game-level latches: per-player
// ready flags, the all-ready flag and the first-press winner (lowest index wins ties).
module leds_racer_input_hub
  import leds_racer_input_hub_pkg::*;
#(
  parameter int NUM_PLAYERS      = 4,
  parameter int DEBOUNCE_CLK_CNT = 65536,
  parameter int LOCKOUT_CLK_CNT  = 0
) (
  input logic                  clk,
  input logic                  reset,
  leds_racer_input_hub_if.slave hub
);

  localparam int ID_W = id_width(NUM_PLAYERS);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS) begin : g_bad_players
    $error("leds_racer_input_hub: NUM_PLAYERS out of range");
  end
  if (DEBOUNCE_CLK_CNT < 1) begin : g_bad_debounce
    $error("leds_racer_input_hub: DEBOUNCE_CLK_CNT must be at least 1");
  end

  logic [NUM_PLAYERS-1:0] level_w;
  logic [NUM_PLAYERS-1:0] press_w;
  logic [NUM_PLAYERS-1:0] ready_q;
  logic                   all_ready_q;
  logic                   first_valid_q;
  logic [ID_W-1:0]        first_id_q;

  // Lowest set index of a press vector; used to break winner ties.
  function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
    leds_racer_debounce_ch #(
      .DEBOUNCE_CLK_CNT (DEBOUNCE_CLK_CNT),
      .LOCKOUT_CLK_CNT  (LOCKOUT_CLK_CNT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .btn_in    (hub.btn_in[g]),
      .btn_level (level_w[g]),
      .btn_press (press_w[g])
    );
  end

  // Ready flags set on a press while enabled; clear wins over a same-cycle press.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= '0;
      all_ready_q <= 1'b0;
    end else begin
      if (hub.clear) begin
        ready_q <= '0;
      end else if (hub.ready_en) begin
        ready_q <= ready_q | press_w;
      end
      all_ready_q <= &ready_q;
    end
  end

  // Capture the first press while the race is armed; later presses wait for clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else if (hub.clear) begin
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
    end else if (hub.race_armed && !first_valid_q && (|press_w)) begin
      first_valid_q <= 1'b1;
      first_id_q    <= lowest_idx(press_w);
    end
  end

  assign hub.btn_level   = level_w;
  assign hub.btn_press   = press_w;
  assign hub.ready       = ready_q;
  assign hub.all_ready   = all_ready_q;
  assign hub.first_valid = first_valid_q;
  assign hub.first_id    = first_id_q;

endmodule

// File: tb/tb_leds_racer_input_hub.sv
// Bench for the LEDs racer input hub: a 4-player hub (debounce 4, lockout 8)
// and a 1-player hub (debounce 1, no lockout). Stimulus pushes expected press
// pulses and timed state expectations; a negedge monitor pops and compares them.
module tb_leds_racer_input_hub;

  localparam int SEL_LEVEL = 0;
  localparam int SEL_READY = 1;
  localparam int SEL_ALLR  = 2;
  localparam int SEL_FV    = 3;
  localparam int SEL_FID   = 4;
  localparam int SEL_L2    = 5;
  localparam int SEL_P2    = 6;
  localparam int SEL_FV2   = 7;
  localparam int SEL_FID2  = 8;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } press_t;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
  } chk_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  press_t press_q[$];
  chk_t   state_q[$];

  leds_racer_input_hub_if #(.NUM_PLAYERS(4)) if1 ();
  leds_racer_input_hub_if #(.NUM_PLAYERS(1)) if2 ();

  leds_racer_input_hub #(
    .NUM_PLAYERS      (4),
    .DEBOUNCE_CLK_CNT (4),
    .LOCKOUT_CLK_CNT  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hub   (if1)
  );

  leds_racer_input_hub #(
    .NUM_PLAYERS      (1),
    .DEBOUNCE_CLK_CNT (1),
    .LOCKOUT_CLK_CNT  (0)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .hub   (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] get_sel(input int s);
    case (s)
      SEL_LEVEL: return 32'(if1.btn_level);
      SEL_READY: return 32'(if1.ready);
      SEL_ALLR:  return 32'(if1.all_ready);
      SEL_FV:    return 32'(if1.first_valid);
      SEL_FID:   return 32'(if1.first_id);
      SEL_L2:    return 32'(if2.btn_level);
      SEL_P2:    return 32'(if2.btn_press);
      SEL_FV2:   return 32'(if2.first_valid);
      SEL_FID2:  return 32'(if2.first_id);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      SEL_LEVEL: return "btn_level";
      SEL_READY: return "ready";
      SEL_ALLR:  return "all_ready";
      SEL_FV:    return "first_valid";
      SEL_FID:   return "first_id";
      SEL_L2:    return "p1cfg_btn_level";
      SEL_P2:    return "p1cfg_btn_press";
      SEL_FV2:   return "p1cfg_first_valid";
      SEL_FID2:  return "p1cfg_first_id";
      default:   return "unknown";
    endcase
  endfunction

  task automatic push_press(input int c, input logic [3:0] v);
    press_t e;
    e.cyc = c;
    e.vec = v;
    press_q.push_back(e);
  endtask

  task automatic push_chk(input int c, input int s, input logic [31:0] v);
    chk_t e;
    int   idx;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    idx = state_q.size();
    for (int i = 0; i < state_q.size(); i++) begin
      if (state_q[i].cyc > c) begin
        idx = i;
        break;
      end
    end
    state_q.insert(idx, e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every press pulse and every due state expectation.
  always @(negedge clk) begin
    press_t      pe;
    chk_t        se;
    logic [31:0] act;
    if (if1.btn_press != 4'h0) begin
      n_cmp++;
      if (press_q.size() == 0) begin
        n_bad++;
        $display("FAIL press_unexpected cyc=%0d got=%b expected=none", cyc, if1.btn_press);
      end else begin
        pe = press_q.pop_front();
        if (pe.cyc != cyc || pe.vec != if1.btn_press) begin
          n_bad++;
          $display("FAIL press cyc=%0d got=%b expected=%b@cyc%0d", cyc, if1.btn_press, pe.vec, pe.cyc);
        end
      end
    end
    while (state_q.size() > 0 && state_q[0].cyc <= cyc) begin
      se  = state_q.pop_front();
      act = get_sel(se.sel);
      n_cmp++;
      if (se.cyc != cyc || act != se.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%0h expected=%0h@cyc%0d", sel_name(se.sel), cyc, act, se.val, se.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    cyc            = 0;
    n_cmp          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    if1.btn_in     = 4'hF;
    if1.clear      = 1'b0;
    if1.ready_en   = 1'b0;
    if1.race_armed = 1'b0;
    if2.btn_in     = 1'b0;
    if2.clear      = 1'b0;
    if2.ready_en   = 1'b0;
    if2.race_armed = 1'b0;

    // Reset held three edges with all buttons down.
    push_chk(1, SEL_LEVEL, 0);
    push_chk(3, SEL_LEVEL, 0);
    push_chk(3, SEL_READY, 0);
    push_chk(3, SEL_ALLR,  0);
    push_chk(3, SEL_FV,    0);
    push_chk(3, SEL_FID,   0);
    push_chk(3, SEL_L2,    0);
    idle(3);
    reset = 1'b0;
    t = cyc;
    push_chk(t + 5, SEL_LEVEL, 0);
    push_chk(t + 6, SEL_LEVEL, 4'hF);
    push_press(t + 6, 4'hF);
    idle(6);
    if1.btn_in = 4'h0;
    t = cyc;
    push_chk(t + 5, SEL_LEVEL, 4'hF);
    push_chk(t + 6, SEL_LEVEL, 0);
    idle(12);

    // Short glitch on player 1 is rejected.
    t = cyc;
    if1.btn_in = 4'b0010;
    push_chk(t + 5, SEL_LEVEL, 0);
    push_chk(t + 7, SEL_LEVEL, 0);
    idle(3);
    if1.btn_in = 4'h0;
    idle(8);

    // Six-cycle hold on player 1 gives one press.
    t = cyc;
    if1.btn_in = 4'b0010;
    push_chk(t + 5, SEL_LEVEL, 0);
    push_chk(t + 6, SEL_LEVEL, 4'b0010);
    push_press(t + 6, 4'b0010);
    idle(6);
    if1.btn_in = 4'h0;
    push_chk(cyc + 6, SEL_LEVEL, 0);
    idle(12);

    // Lockout on player 0: second tap inside the window dropped, third tap passes.
    t = cyc;
    if1.btn_in = 4'b0001;
    push_press(t + 6, 4'b0001);
    push_chk(t + 6,  SEL_LEVEL, 4'b0001);
    push_chk(t + 10, SEL_LEVEL, 0);
    push_chk(t + 14, SEL_LEVEL, 4'b0001);
    push_chk(t + 18, SEL_LEVEL, 0);
    push_chk(t + 22, SEL_LEVEL, 4'b0001);
    push_press(t + 22, 4'b0001);
    idle(4);
    if1.btn_in = 4'h0;
    idle(4);
    if1.btn_in = 4'b0001;
    idle(4);
    if1.btn_in = 4'h0;
    idle(4);
    if1.btn_in = 4'b0001;
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);

    // Ready flags: players 0,2,3 then player 1.
    if1.ready_en = 1'b1;
    t = cyc;
    if1.btn_in = 4'b1101;
    push_press(t + 6, 4'b1101);
    push_chk(t + 6, SEL_READY, 0);
    push_chk(t + 7, SEL_READY, 4'b1101);
    push_chk(t + 8, SEL_ALLR,  0);
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);
    t = cyc;
    if1.btn_in = 4'b0010;
    push_press(t + 6, 4'b0010);
    push_chk(t + 7, SEL_READY, 4'hF);
    push_chk(t + 7, SEL_ALLR,  0);
    push_chk(t + 8, SEL_ALLR,  1);
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);

    // Clear in the same cycle as a press: latches clear, press not recorded.
    t = cyc;
    if1.btn_in = 4'b0001;
    push_press(t + 6, 4'b0001);
    idle(6);
    if1.clear  = 1'b1;
    if1.btn_in = 4'h0;
    push_chk(t + 7, SEL_READY, 0);
    push_chk(t + 8, SEL_ALLR,  0);
    push_chk(t + 9, SEL_READY, 0);
    idle(1);
    if1.clear = 1'b0;
    idle(12);

    // Winner tie between players 2 and 3.
    if1.ready_en   = 1'b0;
    if1.race_armed = 1'b1;
    t = cyc;
    if1.btn_in = 4'b1100;
    push_press(t + 6, 4'b1100);
    push_chk(t + 6, SEL_FV,  0);
    push_chk(t + 7, SEL_FV,  1);
    push_chk(t + 7, SEL_FID, 2);
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);
    t = cyc;
    if1.btn_in = 4'b0001;
    push_press(t + 6, 4'b0001);
    push_chk(t + 7, SEL_FV,  1);
    push_chk(t + 7, SEL_FID, 2);
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);

    // Clear, then all four press together: all pulse, player 0 wins.
    if1.clear = 1'b1;
    idle(1);
    if1.clear = 1'b0;
    push_chk(cyc, SEL_FV, 0);
    t = cyc;
    if1.btn_in = 4'hF;
    push_press(t + 6, 4'hF);
    push_chk(t + 7, SEL_FV,    1);
    push_chk(t + 7, SEL_FID,   0);
    push_chk(t + 7, SEL_READY, 0);
    idle(6);
    if1.btn_in = 4'h0;
    idle(12);

    // Single-player build with one-cycle debounce.
    if2.race_armed = 1'b1;
    t = cyc;
    if2.btn_in = 1'b1;
    push_chk(t + 2, SEL_L2,   0);
    push_chk(t + 3, SEL_L2,   1);
    push_chk(t + 3, SEL_P2,   1);
    push_chk(t + 4, SEL_P2,   0);
    push_chk(t + 4, SEL_FV2,  1);
    push_chk(t + 4, SEL_FID2, 0);
    idle(6);
    if2.btn_in = 1'b0;
    push_chk(cyc + 2, SEL_L2, 1);
    push_chk(cyc + 3, SEL_L2, 0);
    idle(6);

    idle(3);
    while (press_q.size() > 0) begin
      press_t pe;
      pe = press_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL press_missing got=none expected=%b@cyc%0d", pe.vec, pe.cyc);
    end
    while (state_q.size() > 0) begin
      chk_t se;
      se = state_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s_missing got=none expected=%0h@cyc%0d", sel_name(se.sel), se.val, se.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
